// File: rtl/alu32_arbiter_pkg.sv
// Shared ALU control codes, legality check and arbiter state encoding
// for the two-requester ALU arbiter.
package alu32_arbiter_pkg;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic alu_ctl_legal(input logic [2:0] ctl);
        return (ctl >= ALU_ADD) && (ctl <= ALU_XOR);
    endfunction

endpackage

// File: rtl/alu32_arbiter_alu.sv
// Combinational 32-bit ALU: add/sub with signed overflow, bitwise ops,
// zero and negative flags derived from the result.
module alu32
    import alu32_arbiter_pkg::*;
(
    output logic [31:0] out,
    output logic        overflow,
    output logic        zero,
    output logic        negative,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  control
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        out      = '0;
        overflow = 1'b0;
        case (control)
            ALU_ADD: begin
                out      = sum;
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                out      = diff;
                overflow = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_NOR: out = ~(a | b);
            ALU_XOR: out = a ^ b;
            default: out = '0;
        endcase
    end

    assign zero     = (out == 32'd0);
    assign negative = out[31];

endmodule

// File: rtl/alu32_arbiter.sv
// Round-robin arbiter sharing one alu32 between two requesters; the granted
// operands are registered and the result is held on a single response channel.
module alu32_arbiter
    import alu32_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    input  logic [2:0]       req_ctl0,
    input  logic [2:0]       req_ctl1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_out,
    output logic             resp_overflow,
    output logic             resp_zero,
    output logic             resp_negative,
    output logic             resp_err,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic             state_dbg
);

    // Handshake: a request beat transfers when req_valid[i] && req_ready[i];
    // a response transfers when resp_valid && resp_ready. req_ready is
    // combinational from req_valid, rr and state, so it may not feed req_valid.

    state_e      state, state_next;
    logic        rr;
    logic        accept_ok;
    logic [1:0]  grant;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_ctl;
    logic        op_id;
    logic        op_legal;
    logic [31:0] alu_out;
    logic        alu_overflow, alu_zero, alu_negative;

    always_comb begin
        grant     = 2'b00;
        accept_ok = (state == ST_IDLE) || ((state == ST_BUSY) && resp_ready);
        if (reset && accept_ok) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        if (grant != 2'b00) begin
            state_next = ST_BUSY;
        end else if ((state == ST_BUSY) && resp_ready) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rr         <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_ctl     <= '0;
            op_id      <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state <= state_next;
            if (grant != 2'b00) begin
                op_a   <= grant[1] ? req_a1 : req_a0;
                op_b   <= grant[1] ? req_b1 : req_b0;
                op_ctl <= grant[1] ? req_ctl1 : req_ctl0;
                op_id  <= grant[1];
                rr     <= ~grant[1];
            end
            // Counters stick at all-ones rather than wrapping.
            if (grant[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (grant[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

    alu32 u_alu (
        .out      (alu_out),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .negative (alu_negative),
        .a        (op_a),
        .b        (op_b),
        .control  (op_ctl)
    );

    // Illegal codes report a bare error: the ALU's zero flag would read 1 on
    // its forced-zero result, so every flag is masked here.
    assign op_legal      = alu_ctl_legal(op_ctl);
    assign req_ready     = grant;
    assign resp_valid    = (state == ST_BUSY);
    assign resp_id       = op_id;
    assign resp_out      = op_legal ? alu_out : 32'd0;
    assign resp_overflow = op_legal && alu_overflow;
    assign resp_zero     = op_legal && alu_zero;
    assign resp_negative = op_legal && alu_negative;
    assign resp_err      = (state == ST_BUSY) && !op_legal;
    assign state_dbg     = state;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: hand-computed vectors checked with
// immediate assertions; a CNT_W=2 twin shares the stimulus for saturation.
module tb_alu32_arbiter;
    import alu32_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [2:0]  req_ctl0, req_ctl1;
    logic        resp_ready;

    logic [1:0]  req_ready;
    logic        resp_valid, resp_id, resp_overflow, resp_zero, resp_negative, resp_err;
    logic [31:0] resp_out;
    logic [15:0] grant_cnt0, grant_cnt1;
    logic        state_dbg;

    logic [1:0]  s_req_ready;
    logic        s_resp_valid, s_resp_id, s_resp_overflow, s_resp_zero, s_resp_negative, s_resp_err;
    logic [31:0] s_resp_out;
    logic [1:0]  s_cnt0, s_cnt1;
    logic        s_state_dbg;

    int checks   = 0;
    int failures = 0;

    alu32_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_ctl0(req_ctl0), .req_ctl1(req_ctl1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_overflow(resp_overflow), .resp_zero(resp_zero),
        .resp_negative(resp_negative), .resp_err(resp_err),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .state_dbg(state_dbg)
    );

    alu32_arbiter #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_ctl0(req_ctl0), .req_ctl1(req_ctl1),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_id(s_resp_id),
        .resp_out(s_resp_out), .resp_overflow(s_resp_overflow), .resp_zero(s_resp_zero),
        .resp_negative(s_resp_negative), .resp_err(s_resp_err),
        .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1), .state_dbg(s_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Checks the full response word: valid, id, out, overflow, zero, negative, err.
    task automatic chk_resp(input string tag, input logic id, input logic [31:0] out,
                            input logic ovf, input logic zro, input logic neg, input logic err);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_id"},    32'(resp_id),    32'(id));
        chk({tag, "_out"},   resp_out,        out);
        chk({tag, "_ovf"},   32'(resp_overflow), 32'(ovf));
        chk({tag, "_zero"},  32'(resp_zero),  32'(zro));
        chk({tag, "_neg"},   32'(resp_negative), 32'(neg));
        chk({tag, "_err"},   32'(resp_err),   32'(err));
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 2'b11;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        req_ctl0 = ALU_ADD; req_ctl1 = ALU_ADD;
        resp_ready = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
        req_valid = 2'b00;
        reset = 1'b1;
        tick();

        // 1: single request from requester 0
        req_a0 = 32'd8; req_b0 = 32'd4; req_ctl0 = ALU_ADD; req_valid = 2'b01;
        #1 chk("t1_req_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        chk_resp("t1", 1'b0, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_cnt0", 32'(grant_cnt0), 32'd1);
        tick();
        chk("t1_idle", 32'(resp_valid), 32'd0);

        // 2: both valid continuously, alternation from rr=0
        do_reset();
        req_a0 = 32'd10; req_b0 = 32'd20; req_ctl0 = ALU_ADD;
        req_a1 = 32'd5;  req_b1 = 32'd3;  req_ctl1 = ALU_XOR;
        req_valid = 2'b11;
        #1 chk("t2_g0", 32'(req_ready), 32'b01);
        tick();
        chk_resp("t2_r0", 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_g1", 32'(req_ready), 32'b10);
        tick();
        chk_resp("t2_r1", 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_g2", 32'(req_ready), 32'b01);
        tick();
        chk("t2_r2_id", 32'(resp_id), 32'd0);
        chk("t2_g3", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b00;
        chk("t2_r3_id", 32'(resp_id), 32'd1);
        chk("t2_cnt0", 32'(grant_cnt0), 32'd2);
        chk("t2_cnt1", 32'(grant_cnt1), 32'd2);
        tick();

        // 3: overflow/negative from requester 1, zero from requester 0
        req_a1 = 32'h7FFF_FFFF; req_b1 = 32'h7FFF_FFFF; req_ctl1 = ALU_ADD;
        req_valid = 2'b10;
        #1 chk("t3_g1", 32'(req_ready), 32'b10);
        tick();
        req_valid = 2'b00;
        chk_resp("t3_ovf", 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        req_a0 = 32'd6; req_b0 = 32'd6; req_ctl0 = ALU_SUB; req_valid = 2'b01;
        #1 chk("t3_g0", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        chk_resp("t3_zero", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // 4: backpressure holds the response and blocks grants (rr=1 here)
        req_a0 = 32'd100; req_b0 = 32'd1;    req_ctl0 = ALU_SUB;
        req_a1 = 32'hF0;  req_b1 = 32'h0F;   req_ctl1 = ALU_OR;
        req_valid = 2'b11;
        #1 chk("t4_g1", 32'(req_ready), 32'b10);
        tick();
        resp_ready = 1'b0;
        req_a1 = 32'd0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_bp_ready", 32'(req_ready), 32'b00);
            chk_resp("t4_bp", 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        resp_ready = 1'b1;
        #1 chk("t4_release", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        chk_resp("t4_next", 1'b0, 32'd99, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t4_idle", 32'(resp_valid), 32'd0);
        chk("t4_cnt0", 32'(grant_cnt0), 32'd4);
        chk("t4_cnt1", 32'(grant_cnt1), 32'd4);
        chk("t4_sat0", 32'(s_cnt0), 32'd3);
        chk("t4_sat1", 32'(s_cnt1), 32'd3);

        // 5: illegal control code, then a legal op clears the error
        req_a0 = 32'd5; req_b0 = 32'd5; req_ctl0 = 3'b000; req_valid = 2'b01;
        #1 chk("t5_g0", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        chk_resp("t5_ill", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        req_a0 = 32'hC; req_b0 = 32'hA; req_ctl0 = ALU_AND; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk_resp("t5_legal", 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_sat0", 32'(s_cnt0), 32'd3);
        tick();

        // 6: asynchronous reset while a result is held
        req_a0 = 32'd1; req_b0 = 32'd1; req_ctl0 = ALU_ADD; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        resp_ready = 1'b0;
        chk("t6_busy", 32'(resp_valid), 32'd1);
        #2 reset = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t6_rst_valid", 32'(resp_valid), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'b00);
        chk("t6_rst_err", 32'(resp_err), 32'd0);
        chk("t6_rst_cnt0", 32'(grant_cnt0), 32'd0);
        chk("t6_rst_cnt1", 32'(grant_cnt1), 32'd0);
        #1 reset = 1'b1;
        resp_ready = 1'b1;
        #1 chk("t6_first_grant", 32'(req_ready), 32'b01);
        tick();
        req_valid = 2'b00;
        chk_resp("t6_post", 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_small_cnt0", 32'(s_cnt0), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
